// File: rtl/capture_scheduler.sv
// Round-robin scheduler sharing one ADC->DDR3->Ethernet capture path among NUM_CH requesters.
// Steers the ADC mux, fires start_sample, tracks delivered words and aborts hung captures.
module capture_scheduler #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CH_W        = 2,
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned TIMEOUT_CYC = 100_000_000,
   parameter int unsigned RST_CYC     = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ddr_init_done,
   input  logic [NUM_CH-1:0]    ch_req,
   input  logic [NUM_CH*32-1:0] ch_sample_num,
   input  logic                 eth_fifo_wrreq,
   output logic [NUM_CH-1:0]    ch_ack,
   output logic [NUM_CH-1:0]    ch_err,
   output logic                 start_sample,
   output logic [31:0]          set_sample_num,
   output logic [CH_W-1:0]      adc_ch_sel,
   output logic                 ctrl_rst,
   output logic                 busy
);

   typedef enum logic [2:0] {IDLE, ARB, SETTLE, START, RUN, DONE, ABORT} state_t;

   state_t            state, state_nxt;
   logic [CH_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [CH_W-1:0]   gnt_idx, gnt_idx_nxt;
   logic [CH_W-1:0]   sel_nxt;
   logic [31:0]       num_nxt;
   logic [31:0]       cnt, cnt_nxt;
   logic [31:0]       wcnt, wcnt_nxt;
   logic [31:0]       wdog, wdog_nxt;
   logic              start_nxt, crst_nxt;
   logic [NUM_CH-1:0] ack_nxt, err_nxt;
   logic [CH_W:0]     pick;
   logic [CH_W-1:0]   pick_idx;
   logic [31:0]       pick_num;

   // First requesting channel at or above ptr, wrapping; MSB flags a hit.
   function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [CH_W-1:0]   ptr);
      logic [CH_W:0] r;
      int            j;
      r = '0;
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % int'(NUM_CH);
         if (req[j]) r = {1'b1, CH_W'(j)};
      end
      return r;
   endfunction

   function automatic logic [CH_W-1:0] ptr_after(input logic [CH_W-1:0] idx);
      return (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
   endfunction

   function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
      return {{(NUM_CH-1){1'b0}}, 1'b1} << idx;
   endfunction

   assign pick     = rr_pick(ch_req, rr_ptr);
   assign pick_idx = pick[CH_W-1:0];
   assign pick_num = ch_sample_num[32*pick_idx +: 32];
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      rr_ptr_nxt  = rr_ptr;
      gnt_idx_nxt = gnt_idx;
      sel_nxt     = adc_ch_sel;
      num_nxt     = set_sample_num;
      cnt_nxt     = cnt;
      wcnt_nxt    = wcnt;
      wdog_nxt    = wdog;
      start_nxt   = 1'b0;
      crst_nxt    = 1'b0;
      ack_nxt     = '0;
      err_nxt     = '0;
      case (state)
         IDLE: begin
            if (ddr_init_done && |ch_req) state_nxt = ARB;
         end
         ARB: begin
            if (pick[CH_W]) begin
               gnt_idx_nxt = pick_idx;
               sel_nxt     = pick_idx;
               num_nxt     = pick_num;
               cnt_nxt     = '0;
               if (pick_num == 32'd0) begin
                  err_nxt    = onehot(pick_idx);
                  rr_ptr_nxt = ptr_after(pick_idx);
                  state_nxt  = IDLE;
               end else begin
                  state_nxt  = SETTLE;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         SETTLE: begin
            if (cnt == SETTLE_CYC - 1) begin
               start_nxt = 1'b1;
               state_nxt = START;
            end else begin
               cnt_nxt = cnt + 32'd1;
            end
         end
         START: begin
            wcnt_nxt  = '0;
            wdog_nxt  = '0;
            state_nxt = RUN;
         end
         RUN: begin
            // Completion takes priority over a watchdog expiring in the same cycle.
            if (eth_fifo_wrreq && (wcnt + 32'd1 == set_sample_num)) begin
               wcnt_nxt  = wcnt + 32'd1;
               ack_nxt   = onehot(gnt_idx);
               state_nxt = DONE;
            end else if (wdog == TIMEOUT_CYC - 1) begin
               err_nxt   = onehot(gnt_idx);
               crst_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ABORT;
            end else begin
               if (eth_fifo_wrreq) wcnt_nxt = wcnt + 32'd1;
               wdog_nxt = wdog + 32'd1;
            end
         end
         DONE: begin
            rr_ptr_nxt = ptr_after(gnt_idx);
            state_nxt  = IDLE;
         end
         ABORT: begin
            if (cnt == RST_CYC - 1) begin
               rr_ptr_nxt = ptr_after(gnt_idx);
               state_nxt  = IDLE;
            end else begin
               cnt_nxt  = cnt + 32'd1;
               crst_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         gnt_idx        <= '0;
         adc_ch_sel     <= '0;
         set_sample_num <= '0;
         cnt            <= '0;
         wcnt           <= '0;
         wdog           <= '0;
         start_sample   <= 1'b0;
         ctrl_rst       <= 1'b0;
         ch_ack         <= '0;
         ch_err         <= '0;
      end else begin
         state          <= state_nxt;
         rr_ptr         <= rr_ptr_nxt;
         gnt_idx        <= gnt_idx_nxt;
         adc_ch_sel     <= sel_nxt;
         set_sample_num <= num_nxt;
         cnt            <= cnt_nxt;
         wcnt           <= wcnt_nxt;
         wdog           <= wdog_nxt;
         start_sample   <= start_nxt;
         ctrl_rst       <= crst_nxt;
         ch_ack         <= ack_nxt;
         ch_err         <= err_nxt;
      end
   end

endmodule
